// File: rtl/fetch_bpred_unit.sv
// Instruction-fetch stage with a direct-mapped BTB and 2-bit saturating counters.
// Owns the PC and the IF/ID register. Branches resolved in ID redirect the PC on a mispredict.
module fetch_bpred_unit #(
    parameter int              XLEN     = 32,
    parameter int              BTB_IDX  = 6,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_npc,
    output logic [31:0]     if_id_ir,
    output logic            if_id_pred_taken,
    output logic [XLEN-1:0] if_id_pred_tgt,
    input  logic            id_br_valid,
    input  logic            id_br_taken,
    input  logic [XLEN-1:0] id_br_target,
    output logic            redirect,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts
);

    localparam int ENTRIES = 1 << BTB_IDX;
    localparam int TAG_W   = XLEN - BTB_IDX - 2;

    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_next;
    logic [XLEN-1:0]  seq_pc;

    logic             btb_valid [ENTRIES];
    logic [TAG_W-1:0] btb_tag   [ENTRIES];
    logic [XLEN-1:0]  btb_tgt   [ENTRIES];
    logic [1:0]       btb_ctr   [ENTRIES];

    // Fetch-side lookup
    logic [BTB_IDX-1:0] f_idx;
    logic [TAG_W-1:0]   f_tag;
    logic               f_hit;
    logic               f_pred_taken;
    logic [XLEN-1:0]    f_pred_tgt;

    // Decode-side lookup, used for training the entry of the resolving branch
    logic [BTB_IDX-1:0] d_idx;
    logic [TAG_W-1:0]   d_tag;
    logic               d_hit;
    logic [1:0]         d_ctr;
    logic [1:0]         ctr_upd;

    logic               train;
    logic               mispredict;

    assign imem_addr = pc;
    assign seq_pc    = pc + XLEN'(4);

    assign f_idx        = pc[BTB_IDX+1:2];
    assign f_tag        = pc[XLEN-1:BTB_IDX+2];
    assign f_hit        = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);
    assign f_pred_taken = f_hit && btb_ctr[f_idx][1];
    assign f_pred_tgt   = btb_tgt[f_idx];

    assign d_idx = if_id_pc[BTB_IDX+1:2];
    assign d_tag = if_id_pc[XLEN-1:BTB_IDX+2];
    assign d_hit = btb_valid[d_idx] && (btb_tag[d_idx] == d_tag);
    assign d_ctr = btb_ctr[d_idx];

    // id_br_valid is a one-sided qualifier: a resolution takes effect only in a
    // cycle where stall is low; while stalled it is ignored and must be re-presented.
    assign train = id_br_valid && !stall;

    always_comb begin
        mispredict = 1'b0;
        if (train) begin
            if (if_id_pred_taken != id_br_taken) begin
                mispredict = 1'b1;
            end else if (id_br_taken && if_id_pred_taken && (if_id_pred_tgt != id_br_target)) begin
                mispredict = 1'b1;
            end
        end
    end

    assign redirect = mispredict;

    always_comb begin
        pc_next = seq_pc;
        if (stall) begin
            pc_next = pc;
        end else if (mispredict) begin
            pc_next = id_br_taken ? id_br_target : if_id_npc;
        end else if (f_pred_taken) begin
            pc_next = f_pred_tgt;
        end
    end

    always_comb begin
        ctr_upd = d_ctr;
        if (id_br_taken) begin
            if (d_ctr != 2'b11) begin
                ctr_upd = d_ctr + 2'b01;
            end
        end else begin
            if (d_ctr != 2'b00) begin
                ctr_upd = d_ctr - 2'b01;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_pc         <= '0;
            if_id_npc        <= '0;
            if_id_ir         <= '0;
            if_id_pred_taken <= 1'b0;
            if_id_pred_tgt   <= '0;
        end else if (!stall) begin
            if (mispredict) begin
                if_id_pc         <= '0;
                if_id_npc        <= '0;
                if_id_ir         <= '0;
                if_id_pred_taken <= 1'b0;
                if_id_pred_tgt   <= '0;
            end else begin
                if_id_pc         <= pc;
                if_id_npc        <= seq_pc;
                if_id_ir         <= imem_rdata;
                if_id_pred_taken <= f_pred_taken;
                if_id_pred_tgt   <= f_pred_taken ? f_pred_tgt : '0;
            end
        end
    end

    // A not-taken branch that misses never allocates nor disturbs the counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid[i] <= 1'b0;
                btb_tag[i]   <= '0;
                btb_tgt[i]   <= '0;
                btb_ctr[i]   <= 2'b01;
            end
        end else if (train) begin
            if (id_br_taken || d_hit) begin
                btb_ctr[d_idx] <= ctr_upd;
            end
            if (id_br_taken) begin
                btb_valid[d_idx] <= 1'b1;
                btb_tag[d_idx]   <= d_tag;
                btb_tgt[d_idx]   <= id_br_target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else if (train) begin
            perf_branches <= perf_branches + 32'd1;
            if (mispredict) begin
                perf_mispredicts <= perf_mispredicts + 32'd1;
            end
        end
    end

endmodule
